// File: rtl/uart_rx_fifo_param_if.sv
// Bus between the UART receive FIFO and its users: receiver push side, APB read side and status.
// The FIFO takes the slave modport; the register bank / bench takes the master modport.
interface uart_rx_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 4
);
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rd_en;
    logic              flush;
    logic              ovr_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              thresh_hit;
    logic [AW:0]       level;
    logic              overrun;
    logic              irq;

    modport master (
        output rx_done, rx_data, rd_en, flush, ovr_clr,
        input  rd_data, rd_valid, full, empty, thresh_hit, level, overrun, irq
    );

    modport slave (
        input  rx_done, rx_data, rd_en, flush, ovr_clr,
        output rd_data, rd_valid, full, empty, thresh_hit, level, overrun, irq
    );
endinterface

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receive FIFO: pushes on rx_done rising edge, pops on APB read strobes,
// with occupancy level, threshold, sticky overrun, flush and interrupt request.
module uart_rx_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned RX_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_fifo_param_if.slave  bus
);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t ThreshLvl = ptr_t'(RX_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;
    logic              rx_done_q, rx_done_d;

    logic              push_req;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    ptr_t              level;

    // Status is decoded purely from registered pointers, so it cannot glitch on input changes.
    always_comb begin
        push_req = bus.rx_done & ~rx_done_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level    = wr_ptr_q - rd_ptr_q;
        do_push  = push_req & ~full & ~bus.flush;
        do_pop   = bus.rd_en & ~empty & ~bus.flush;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overrun_d  = overrun_q;
        rx_done_d  = bus.rx_done;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                rd_valid_d = 1'b1;
            end
        end

        // Full is judged before the edge: a slot freed by a same-cycle pop is not reused.
        if (push_req && full) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            rx_done_q  <= rx_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.level      = level;
    assign bus.thresh_hit = (level >= ThreshLvl);
    assign bus.overrun    = overrun_q;
    assign bus.irq        = (level >= ThreshLvl) | overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: a byte queue holds what should come out of the FIFO,
// and every pop and status sample is compared against it with immediate assertions.
module tb_uart_rx_fifo_param;
    localparam int unsigned DataW = 8;
    localparam int unsigned Depth = 16;
    localparam int unsigned Aw    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_fifo_param_if #(.DATA_W(DataW), .AW(Aw)) bus_if ();

    uart_rx_fifo_param #(
        .DATA_W   (DataW),
        .DEPTH    (Depth),
        .AW       (Aw),
        .RX_THRESH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    logic [DataW-1:0] sb_q[$];
    logic             exp_ovr = 1'b0;
    int               n_cmp   = 0;
    int               n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clean rx_done pulse (high one cycle, low one cycle).
    task automatic push_byte(input logic [DataW-1:0] b);
        @(negedge clk);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = b;
        if (sb_q.size() < Depth) sb_q.push_back(b);
        else exp_ovr = 1'b1;
        @(negedge clk);
        bus_if.rx_done = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [DataW-1:0] exp;
        @(negedge clk);
        bus_if.rd_en = 1'b1;
        @(negedge clk);
        bus_if.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus_if.rd_valid), 32'(sb_q.size() > 0));
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(exp));
        end
    endtask

    // Push edge and read strobe in the same cycle; model pops before pushing.
    task automatic push_pop(input string tag, input logic [DataW-1:0] b);
        int               pre;
        logic [DataW-1:0] exp;
        @(negedge clk);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = b;
        bus_if.rd_en   = 1'b1;
        pre = sb_q.size();
        @(negedge clk);
        bus_if.rx_done = 1'b0;
        bus_if.rd_en   = 1'b0;
        chk({tag, "_valid"}, 32'(bus_if.rd_valid), 32'(pre > 0));
        if (pre > 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(exp));
        end
        if (pre < Depth) sb_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    initial begin
        bus_if.rx_done = 1'b0;
        bus_if.rx_data = '0;
        bus_if.rd_en   = 1'b0;
        bus_if.flush   = 1'b0;
        bus_if.ovr_clr = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", 32'(bus_if.empty), 1);
        chk("rst_full", 32'(bus_if.full), 0);
        chk("rst_level", 32'(bus_if.level), 0);
        chk("rst_rd_data", 32'(bus_if.rd_data), 0);
        chk("rst_rd_valid", 32'(bus_if.rd_valid), 0);
        chk("rst_overrun", 32'(bus_if.overrun), 0);
        chk("rst_irq", 32'(bus_if.irq), 0);
        rst = 1'b1;

        // Long rx_done level gives one push
        @(negedge clk);
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = 8'hA5;
        sb_q.push_back(8'hA5);
        repeat (5) @(negedge clk);
        bus_if.rx_done = 1'b0;
        chk("hold_level", 32'(bus_if.level), 1);
        pop_chk("a5_pop");
        chk("a5_empty", 32'(bus_if.empty), 1);

        // Fill, threshold, overrun, ordered drain
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
            chk($sformatf("thr_%0d", i), 32'(bus_if.thresh_hit), 32'(i >= 7));
        end
        chk("fill_full", 32'(bus_if.full), 1);
        chk("fill_level", 32'(bus_if.level), 16);
        push_byte(8'hFF);
        chk("ovr_set", 32'(bus_if.overrun), 32'(exp_ovr));
        chk("ovr_level", 32'(bus_if.level), 16);
        chk("ovr_irq", 32'(bus_if.irq), 1);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("drain_%0d", i));
        chk("drain_empty", 32'(bus_if.empty), 1);
        chk("drain_nothr", 32'(bus_if.thresh_hit), 0);

        @(negedge clk);
        bus_if.ovr_clr = 1'b1;
        exp_ovr = 1'b0;
        @(negedge clk);
        bus_if.ovr_clr = 1'b0;
        chk("clr1_overrun", 32'(bus_if.overrun), 0);

        // Simultaneous push/pop, partially filled then full
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        push_pop("sim3", 8'h55);
        chk("sim3_level", 32'(bus_if.level), 3);
        chk("sim3_overrun", 32'(bus_if.overrun), 0);
        for (int i = 0; i < 13; i++) push_byte(8'h60 + 8'(i));
        chk("sim_full", 32'(bus_if.full), 1);
        push_pop("simfull", 8'h55);
        chk("simfull_level", 32'(bus_if.level), 15);
        chk("simfull_overrun", 32'(bus_if.overrun), 32'(exp_ovr));
        while (sb_q.size() > 0) pop_chk("sim_drain");
        chk("sim_drain_empty", 32'(bus_if.empty), 1);

        // Wrap-around at constant occupancy
        for (int i = 0; i < 10; i++) push_byte(8'hC0 + 8'(i));
        for (int i = 0; i < 24; i++) begin
            push_pop($sformatf("wrap_%0d", i), 8'h80 + 8'(i));
            chk($sformatf("wrap_lvl_%0d", i), 32'(bus_if.level), 10);
        end

        // Flush keeps overrun, ovr_clr then clears irq
        @(negedge clk);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        sb_q.delete();
        chk("flush_empty", 32'(bus_if.empty), 1);
        chk("flush_level", 32'(bus_if.level), 0);
        chk("flush_overrun", 32'(bus_if.overrun), 32'(exp_ovr));
        @(negedge clk);
        bus_if.ovr_clr = 1'b1;
        exp_ovr = 1'b0;
        @(negedge clk);
        bus_if.ovr_clr = 1'b0;
        chk("clr2_overrun", 32'(bus_if.overrun), 0);
        chk("clr2_irq", 32'(bus_if.irq), 0);

        // Read on empty is ignored
        @(negedge clk);
        bus_if.rd_en = 1'b1;
        @(negedge clk);
        bus_if.rd_en = 1'b0;
        chk("rdempty_valid", 32'(bus_if.rd_valid), 0);
        chk("rdempty_level", 32'(bus_if.level), 0);

        // Push and pop together on empty: push wins, pop ignored
        push_pop("simempty", 8'h77);
        chk("simempty_level", 32'(bus_if.level), 1);
        pop_chk("simempty_pop");

        // Mid-operation reset
        for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
        chk("pre_rst_level", 32'(bus_if.level), 5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        chk("mid_rst_level", 32'(bus_if.level), 0);
        chk("mid_rst_empty", 32'(bus_if.empty), 1);
        chk("mid_rst_rd_data", 32'(bus_if.rd_data), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
